button_debouncer: RTL and testbench

Front-end input conditioner for the calculator's push buttons. It synchronizes one raw asynchronous button input, debounces it with a consecutive-sample counter, and emits single-cycle press and release pulses. Those pulses drive the `count_enable` and `clear` strobes of the downstream counter and digit-entry logic, so every physical press yields exactly one enable pulse.

---
 rtl/button_debouncer_if.sv | 32 +++
 rtl/button_debouncer.sv | 206 ++++++++++++++++++++
 tb/tb_button_debouncer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: groups the per-button control and status signals.
//   clear         - synchronous abort into released state (driven by master)
//   btn_in        - raw asynchronous button, active-high (driven by master)
//   btn_level     - debounced button level (driven by slave)
//   press_pulse   - one-cycle strobe on accepted press / repeat (driven by slave)
//   release_pulse - one-cycle strobe on accepted release (driven by slave)
`timescale 1ns/1ps
interface button_debouncer_if;
  logic clear;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  // Consumer side: drives the button and abort, observes the strobes.
  modport master (
    output clear,
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse
  );

  // Debouncer side.
  modport slave (
    input  clear,
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes one raw button, debounces it with a
// consecutive-sample counter and emits single-cycle press/release strobes.
// Optional auto-repeat of press_pulse while held: BUTTON_DEBOUNCER_REPEAT_EN.
// Ports:
//   clk   - single clock, rising edge
//   n_rst - asynchronous active-low reset
//   bus   - button_debouncer_if.slave (clear, btn_in in; btn_level,
//           press_pulse, release_pulse out, all registered)
`timescale 1ns/1ps
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  button_debouncer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             level_q, level_nxt;
  logic             press_q, press_nxt;
  logic             release_q, release_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;

  // Synchronizer chain; deliberately untouched by clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Saturating increment of the debounce counter.
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0] rpt_q, rpt_nxt;
  logic             rpt_armed_q, rpt_armed_nxt;  // set once the hold delay has elapsed
  logic [RPT_W-1:0] rpt_last_c;

  // Long hold interval before the first repeat, short period after.
  assign rpt_last_c = rpt_armed_q ? RPT_W'(REPEAT_CYCLES - 1) : RPT_W'(HOLD_CYCLES - 1);
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{HOLD_CYCLES, REPEAT_CYCLES};
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      level_q   <= level_nxt;
      press_q   <= press_nxt;
      release_q <= release_nxt;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rpt_q       <= rpt_nxt;
      rpt_armed_q <= rpt_armed_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    level_nxt   = level_q;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    rpt_nxt       = rpt_q;
    rpt_armed_nxt = rpt_armed_q;
`endif

    if (bus.clear) begin
      // Abort straight to released without a release strobe.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      level_nxt = 1'b0;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      rpt_nxt       = '0;
      rpt_armed_nxt = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          level_nxt = 1'b0;
          if (btn_sync) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_sync) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            level_nxt = 1'b1;
            press_nxt = 1'b1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            rpt_nxt       = '0;
            rpt_armed_nxt = 1'b0;
`endif
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end

        PRESSED: begin
          level_nxt = 1'b1;
          if (!btn_sync) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_ONE;
          end else begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            // Repeat timer only advances while settled in PRESSED.
            if (rpt_q == rpt_last_c) begin
              press_nxt     = 1'b1;
              rpt_nxt       = '0;
              rpt_armed_nxt = 1'b1;
            end else begin
              rpt_nxt = rpt_q + RPT_W'(1);
            end
`endif
          end
        end

        RELEASE_WAIT: begin
          if (btn_sync) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            level_nxt   = 1'b0;
            release_nxt = 1'b1;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
            rpt_nxt       = '0;
            rpt_armed_nxt = 1'b0;
`endif
          end else begin
            cnt_nxt = cnt_inc_c;
          end
        end

        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed stimulus against a run-length model of the
// debouncer, checked every cycle, plus literal pulse-edge expectations.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DB   = 16;
  localparam int HOLD = 64;
  localparam int RPT  = 16;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  button_debouncer_if bus_if ();

  button_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: accepted level plus length of the current run of opposite samples.
  bit hist[$];
  int run        = 0;
  bit m_lvl      = 1'b0;
  int held       = 0;
  bit first_done = 1'b0;
  bit exp_lvl    = 1'b0;
  bit exp_press  = 1'b0;
  bit exp_rel    = 1'b0;

  int press_q[$];
  int rel_q[$];
  int exp_e[$];
  int base;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist.delete();
      run = 0; m_lvl = 1'b0; held = 0; first_done = 1'b0;
      exp_lvl = 1'b0; exp_press = 1'b0; exp_rel = 1'b0;
    end else begin
      bit s;
      s = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
      hist.push_back(bus_if.btn_in);
      exp_press = 1'b0;
      exp_rel   = 1'b0;
      if (bus_if.clear) begin
        run = 0; m_lvl = 1'b0; held = 0; first_done = 1'b0;
      end else if (s != m_lvl) begin
        run++;
        if (run == DB) begin
          m_lvl = s; run = 0; held = 0; first_done = 1'b0;
          if (s) exp_press = 1'b1;
          else   exp_rel   = 1'b1;
        end
      end else begin
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
        if (m_lvl && run == 0) begin
          held++;
          if (held == (first_done ? RPT : HOLD)) begin
            exp_press = 1'b1; held = 0; first_done = 1'b1;
          end
        end
`endif
        run = 0;
      end
      exp_lvl = m_lvl;
    end
  end

  // Per-cycle compare against the model, and pulse-edge logging.
  always @(negedge clk) begin
    check("btn_level",     int'(bus_if.btn_level),     int'(exp_lvl));
    check("press_pulse",   int'(bus_if.press_pulse),   int'(exp_press));
    check("release_pulse", int'(bus_if.release_pulse), int'(exp_rel));
    check("pulse_overlap", int'(bus_if.press_pulse & bus_if.release_pulse), 0);
    if (bus_if.press_pulse)   press_q.push_back(cyc);
    if (bus_if.release_pulse) rel_q.push_back(cyc);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_phase();
    press_q.delete();
    rel_q.delete();
    base = cyc;
  endtask

  task automatic check_edges(input string name, input bit is_press);
    int got[$];
    if (is_press) got = press_q;
    else          got = rel_q;
    check({name, "_count"}, got.size(), exp_e.size());
    for (int i = 0; i < exp_e.size() && i < got.size(); i++)
      check($sformatf("%s_edge[%0d]", name, i), got[i] - base, exp_e[i]);
  endtask

  initial begin
    bus_if.clear  = 1'b0;
    bus_if.btn_in = 1'b1;

    // Reset with button held high.
    cycles(2);
    check("rst_level",   int'(bus_if.btn_level),     0);
    check("rst_press",   int'(bus_if.press_pulse),   0);
    check("rst_release", int'(bus_if.release_pulse), 0);
    n_rst = 1'b1;
    cycles(1);
    check("post_rst_level",   int'(bus_if.btn_level),     0);
    check("post_rst_press",   int'(bus_if.press_pulse),   0);
    check("post_rst_release", int'(bus_if.release_pulse), 0);
    n_rst = 1'b0;
    bus_if.btn_in = 1'b0;
    cycles(2);
    n_rst = 1'b1;
    cycles(3);

    // Clean press.
    start_phase();
    bus_if.btn_in = 1'b1;
    cycles(17);
    check("press_level_e17", int'(bus_if.btn_level), 0);
    cycles(1);
    check("press_level_e18", int'(bus_if.btn_level), 1);
    check("press_pulse_e18", int'(bus_if.press_pulse), 1);
    cycles(7);
    exp_e.delete(); exp_e.push_back(18);
    check_edges("clean_press", 1'b1);
    exp_e.delete();
    check_edges("clean_press_rel", 1'b0);

    // Release.
    start_phase();
    bus_if.btn_in = 1'b0;
    cycles(25);
    exp_e.delete(); exp_e.push_back(18);
    check_edges("release", 1'b0);
    exp_e.delete();
    check_edges("release_press", 1'b1);
    check("release_level", int'(bus_if.btn_level), 0);

    // Bounce on press.
    start_phase();
    bus_if.btn_in = 1'b1;
    cycles(10);
    bus_if.btn_in = 1'b0;
    cycles(1);
    bus_if.btn_in = 1'b1;
    cycles(30);
    exp_e.delete(); exp_e.push_back(29);
    check_edges("bounce", 1'b1);
    bus_if.btn_in = 1'b0;
    cycles(25);

    // Glitch while held: no release, no extra press.
    bus_if.btn_in = 1'b1;
    cycles(25);
    start_phase();
    bus_if.btn_in = 1'b0;
    cycles(5);
    bus_if.btn_in = 1'b1;
    cycles(30);
    exp_e.delete();
    check_edges("glitch_press", 1'b1);
    check_edges("glitch_rel", 1'b0);
    check("glitch_level", int'(bus_if.btn_level), 1);
    bus_if.btn_in = 1'b0;
    cycles(25);

    // Clear mid-debounce, sampled at the 8th FSM sample (edge 10).
    start_phase();
    bus_if.btn_in = 1'b1;
    cycles(9);
    bus_if.clear = 1'b1;
    cycles(1);
    bus_if.clear = 1'b0;
    cycles(25);
    exp_e.delete(); exp_e.push_back(26);
    check_edges("clear_debounce", 1'b1);

    // Clear while pressed: level drops, no release, fresh press after re-debounce.
    start_phase();
    bus_if.clear = 1'b1;
    cycles(1);
    bus_if.clear = 1'b0;
    check("clear_pressed_level", int'(bus_if.btn_level), 0);
    cycles(24);
    exp_e.delete(); exp_e.push_back(17);
    check_edges("clear_pressed_press", 1'b1);
    exp_e.delete();
    check_edges("clear_pressed_rel", 1'b0);
    bus_if.btn_in = 1'b0;
    cycles(25);

    // Long hold: auto-repeat only when built in.
    start_phase();
    bus_if.btn_in = 1'b1;
    cycles(200);
    exp_e.delete();
    exp_e.push_back(18);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    exp_e.push_back(82);  exp_e.push_back(98);  exp_e.push_back(114);
    exp_e.push_back(130); exp_e.push_back(146); exp_e.push_back(162);
    exp_e.push_back(178); exp_e.push_back(194);
`endif
    check_edges("hold", 1'b1);
    start_phase();
    bus_if.btn_in = 1'b0;
    cycles(25);
    exp_e.delete(); exp_e.push_back(18);
    check_edges("hold_release", 1'b0);

    // Asynchronous reset while pressed.
    bus_if.btn_in = 1'b1;
    cycles(25);
    check("pre_async_level", int'(bus_if.btn_level), 1);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_level",   int'(bus_if.btn_level),     0);
    check("async_rst_press",   int'(bus_if.press_pulse),   0);
    check("async_rst_release", int'(bus_if.release_pulse), 0);
    cycles(2);
    bus_if.btn_in = 1'b0;
    n_rst = 1'b1;
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
